// File: rtl/fs_pkg.sv
// fs_pkg: shared state encoding and sizing helper for the serial subtractor
package fs_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/fs_cell.sv
// fs_cell: one-bit full subtractor x - y - z
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic dout,
  output logic bout
);
  assign dout = x ^ y ^ z;
  assign bout = (~x & y) | (~(x ^ y) & z);
endmodule

// File: rtl/fs_serial.sv
// fs_serial: LSB-first bit-serial subtractor with word framing and parallel result
module fs_serial
  import fs_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic         a,
  input  logic         b,
  input  logic         bi,
  output logic         d,
  output logic         bo,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff
);
  localparam int CW = cnt_w(W);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] sr, sr_nx;
  logic brw, z, dout, bout, first, take, last;
  fs_cell u_cell (.x(a), .y(b), .z(z), .dout(dout), .bout(bout));
  assign busy = state == RUN;
  assign done = state == DONE;
  // outside RUN a start begins a new word with bi; inside RUN every cycle carries a bit
  always_comb begin
    first    = state != RUN;
    take     = !first || start;
    z        = first ? bi : brw;
    last     = take && (first ? (W == 1) : (cnt == CW'(W - 1)));
    sr_nx    = W'({dout, sr} >> 1);
    state_nx = last ? DONE : take ? RUN : IDLE;
  end
  // state, serial datapath and word capture; diff only changes on the final bit
  always_ff @(posedge ck) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      sr    <= '0;
      d     <= 1'b0;
      bo    <= 1'b0;
      diff  <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        d   <= dout;
        brw <= bout;
        sr  <= sr_nx;
        cnt <= first ? CW'(1) : cnt + CW'(1);
      end
      if (last) begin
        diff <= sr_nx;
        bo   <= bout;
      end
    end
  end
endmodule

// File: tb/tb_fs_serial.sv
// tb_fs_serial: directed checks of the serial subtractor (W=8 and W=1 builds)
module tb_fs_serial;
  logic ck = 0, rst = 0, start = 0, a = 0, b = 0, bi = 0;
  logic d, bo, busy, done;
  logic [7:0] diff;
  logic s1 = 0, a1 = 0, b1 = 0, bi1 = 0;
  logic d1, bo1, busy1, done1;
  logic [0:0] diff1;
  logic seen_busy1 = 0;
  int n = 0, nf = 0;
  always #5 ck = ~ck;
  fs_serial #(.W(8)) dut (
    .ck(ck), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
    .d(d), .bo(bo), .busy(busy), .done(done), .diff(diff)
  );
  fs_serial #(.W(1)) dut1 (
    .ck(ck), .rst(rst), .start(s1), .a(a1), .b(b1), .bi(bi1),
    .d(d1), .bo(bo1), .busy(busy1), .done(done1), .diff(diff1)
  );
  always @(posedge ck) #1 if (busy1) seen_busy1 = 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic word(input logic [7:0] av, input logic [7:0] bv, input logic bin,
                      input logic [7:0] smask, input logic skip,
                      input logic [7:0] ed, input logic ebo);
    for (int i = 0; i < 8; i++) begin
      if (!(skip && i == 0)) @(negedge ck);
      if (i > 0) begin
        chk("d_stream", d, ed[i-1]);
        chk("busy_run", busy, 1);
        chk("done_mid", done, 0);
      end
      start = (i == 0) || smask[i];
      a = av[i];
      b = bv[i];
      bi = (i == 0) ? bin : 1'b0;
    end
    @(negedge ck);
    start = 0; a = 0; b = 0;
    chk("d_last", d, ed[7]);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("diff", diff, ed);
    chk("bo", bo, ebo);
  endtask
  task automatic idle_after(input logic [7:0] ed, input logic ebo);
    @(negedge ck);
    chk("done_fall", done, 0);
    chk("busy_idle", busy, 0);
    chk("diff_hold", diff, ed);
    chk("bo_hold", bo, ebo);
  endtask
  task automatic w1(input logic av, input logic bv, input logic bin, input logic ed, input logic ebo);
    @(negedge ck);
    s1 = 1; a1 = av; b1 = bv; bi1 = bin;
    @(negedge ck);
    s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    chk("w1_done", done1, 1);
    chk("w1_diff", diff1, ed);
    chk("w1_bo", bo1, ebo);
    chk("w1_d", d1, ed);
    chk("w1_busy", busy1, 0);
    @(negedge ck);
    chk("w1_done_fall", done1, 0);
    chk("w1_diff_hold", diff1, ed);
  endtask
  initial begin
    repeat (2) @(negedge ck);
    chk("rst_d", d, 0); chk("rst_bo", bo, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_diff", diff, 0);
    chk("rst_done1", done1, 0); chk("rst_diff1", diff1, 0);
    rst = 1;
    word(8'd100, 8'd37, 1'b0, 8'h00, 1'b0, 8'd63, 1'b0);
    idle_after(8'd63, 1'b0);
    word(8'd5, 8'd9, 1'b0, 8'h00, 1'b0, 8'd252, 1'b1);
    idle_after(8'd252, 1'b1);
    word(8'd0, 8'd0, 1'b1, 8'h00, 1'b0, 8'd255, 1'b1);
    idle_after(8'd255, 1'b1);
    word(8'd10, 8'd3, 1'b0, 8'h00, 1'b0, 8'd7, 1'b0);
    word(8'd200, 8'd1, 1'b0, 8'h00, 1'b1, 8'd199, 1'b0);
    idle_after(8'd199, 1'b0);
    word(8'd100, 8'd37, 1'b0, 8'b0010_1000, 1'b0, 8'd63, 1'b0);
    idle_after(8'd63, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      start = (i == 0);
      a = 1'(8'd50 >> i);
      b = 1'(8'd20 >> i);
      bi = 0;
      rst = (i != 4);
    end
    @(negedge ck);
    start = 0; a = 0; b = 0; rst = 1;
    chk("abort_d", d, 0); chk("abort_bo", bo, 0); chk("abort_busy", busy, 0);
    chk("abort_done", done, 0); chk("abort_diff", diff, 0);
    @(negedge ck);
    chk("abort_no_done", done, 0);
    word(8'd10, 8'd3, 1'b0, 8'h00, 1'b0, 8'd7, 1'b0);
    idle_after(8'd7, 1'b0);
    w1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    w1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    w1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    w1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("w1_busy_never", seen_busy1, 0);
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
